// File: rtl/fiford_ctl.sv
// Read-side controller for a registered-output FIFO: issues pops, absorbs the one-cycle
// read latency in a two-entry skid buffer and presents a valid/ready stream downstream.
`timescale 1ns/1ps
module fiford_ctl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             en,
    input  logic             notempty,
    input  logic [WIDTH-1:0] fifodout,
    output logic             fiford,
    output logic             dvalid,
    output logic [WIDTH-1:0] dout,
    input  logic             dready,
    output logic [15:0]      wordcnt,
    output logic             busy
);

    logic             inflight_q, inflight_d;
    logic [1:0]       occ_q, occ_d;
    logic             head_q, head_d;
    logic             tail;
    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [15:0]      wordcnt_q, wordcnt_d;
    logic             rst_done_q;
    logic             pop;
    logic [2:0]       level;

    // Holds off pops until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
        end
    end

    always_comb begin
        pop       = (occ_q != 2'd0) & dready;
        // Words committed to the buffer after this edge, counting the one still in flight.
        level     = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        fiford    = rst_done_q & en & notempty & (level < 3'(DEPTH));
        inflight_d = fiford;
        occ_d     = 2'(occ_q + {1'b0, inflight_q} - {1'b0, pop});
        head_d    = head_q ^ pop;
        tail      = head_q ^ occ_q[0];
        wordcnt_d = wordcnt_q + 16'(pop);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= 1'b0;
            wordcnt_q  <= 16'd0;
        end else begin
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            wordcnt_q  <= wordcnt_d;
        end
    end

    // Tail never aliases the head while a word is held, so dout is stable under backpressure.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            buf_q <= '{default: '0};
        end else if (inflight_q) begin
            buf_q[tail] <= fifodout;
        end
    end

    assign dvalid  = (occ_q != 2'd0);
    assign dout    = buf_q[head_q];
    assign wordcnt = wordcnt_q;
    assign busy    = inflight_q | dvalid;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_)
        (32'(occ_q) + 32'(inflight_q)) <= 32'(DEPTH));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_)
        (dvalid && !dready) |=> $stable(dout));

endmodule

// File: tb/tb_fiford_ctl.sv
// Randomised bench for fiford_ctl: a queue-based FIFO and a word-level scoreboard
// predict every output each cycle.
`timescale 1ns/1ps
module tb_fiford_ctl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_ = 1'b1;
    logic         en = 1'b1;
    logic         notempty = 1'b0;
    logic         dready = 1'b1;
    logic [W-1:0] fifodout = '0;
    logic         fiford;
    logic         dvalid;
    logic [W-1:0] dout;
    logic [15:0]  wordcnt;
    logic         busy;

    always #5 clk = ~clk;

    fiford_ctl #(
        .WIDTH(W),
        .DEPTH(2)
    ) dut (
        .clk     (clk),
        .rst_    (rst_),
        .en      (en),
        .notempty(notempty),
        .fifodout(fifodout),
        .fiford  (fiford),
        .dvalid  (dvalid),
        .dout    (dout),
        .dready  (dready),
        .wordcnt (wordcnt),
        .busy    (busy)
    );

    // Reference model: FIFO contents, word read last cycle, words deliverable now.
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] transit_q[$];
    logic [W-1:0] ready_q[$];
    int delivered = 0;
    int reads = 0;
    int cyc = 0;
    int first_pop = -1;
    int last_pop = -1;
    bit started = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        notempty = 1'b1;
    endtask

    // One clock: predict and check outputs at the falling edge, then advance the model.
    task automatic cycle();
        bit exp_valid, exp_pop, exp_rd, fr;
        int level;
        @(negedge clk);
        exp_valid = (ready_q.size() != 0);
        exp_pop   = exp_valid && dready;
        level     = ready_q.size() + transit_q.size() - (exp_pop ? 1 : 0);
        exp_rd    = started && en && (fifo_q.size() != 0) && (level < 2);
        vectors++;
        if (dvalid !== exp_valid) begin
            miscompares++;
            $display("FAIL dvalid: got %b expected %b cycle %0d", dvalid, exp_valid, cyc);
        end
        if (exp_valid) begin
            vectors++;
            if (dout !== ready_q[0]) begin
                miscompares++;
                $display("FAIL dout: got %h expected %h cycle %0d", dout, ready_q[0], cyc);
            end
        end
        vectors++;
        if (fiford !== exp_rd) begin
            miscompares++;
            $display("FAIL fiford: got %b expected %b cycle %0d", fiford, exp_rd, cyc);
        end
        vectors++;
        if (wordcnt !== 16'(delivered)) begin
            miscompares++;
            $display("FAIL wordcnt: got %0d expected %0d cycle %0d", wordcnt, 16'(delivered), cyc);
        end
        vectors++;
        if (busy !== (transit_q.size() != 0 || exp_valid)) begin
            miscompares++;
            $display("FAIL busy: got %b expected %b cycle %0d", busy,
                     (transit_q.size() != 0 || exp_valid), cyc);
        end
        fr = fiford;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_pop) begin
            void'(ready_q.pop_front());
            delivered++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (transit_q.size() != 0) ready_q.push_back(transit_q.pop_front());
        if (fr) begin
            reads++;
            vectors++;
            if (fifo_q.size() != 0) begin
                fifodout = fifo_q.pop_front();
                transit_q.push_back(fifodout);
            end else begin
                miscompares++;
                $display("FAIL fifo_underflow: got pop expected none cycle %0d", cyc);
            end
        end
        started  = 1'b1;
        notempty = (fifo_q.size() != 0);
    endtask

    // Asserts reset asynchronously mid-cycle; leaves the bench just after a rising edge.
    task automatic apply_reset();
        @(negedge clk);
        #2 rst_ = 1'b0;
        #1;
        vectors += 5;
        if (fiford !== 1'b0) begin
            miscompares++; $display("FAIL rst_fiford: got %b expected 0", fiford);
        end
        if (dvalid !== 1'b0) begin
            miscompares++; $display("FAIL rst_dvalid: got %b expected 0", dvalid);
        end
        if (wordcnt !== 16'd0) begin
            miscompares++; $display("FAIL rst_wordcnt: got %0d expected 0", wordcnt);
        end
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL rst_busy: got %b expected 0", busy);
        end
        if (dout !== '0) begin
            miscompares++; $display("FAIL rst_dout: got %h expected 0", dout);
        end
        ready_q.delete();
        transit_q.delete();
        delivered = 0;
        started   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors += 2;
        if (fiford !== 1'b0) begin
            miscompares++; $display("FAIL rst_hold_fiford: got %b expected 0", fiford);
        end
        if (dvalid !== 1'b0) begin
            miscompares++; $display("FAIL rst_hold_dvalid: got %b expected 0", dvalid);
        end
        @(posedge clk);
        #1 rst_ = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b1;
        dready = 1'b1;
        for (int i = 1; i <= 16; i++) push(W'(i));
        apply_reset();
    endtask

    task automatic test_streaming();
        first_pop = -1;
        for (int i = 0; i < 40 && delivered < 16; i++) cycle();
        vectors++;
        if (delivered != 16) begin
            miscompares++; $display("FAIL stream_count: got %0d expected 16", delivered);
        end
        vectors++;
        if (last_pop - first_pop != 15) begin
            miscompares++;
            $display("FAIL stream_gapless: got span %0d expected 15", last_pop - first_pop);
        end
        repeat (3) cycle();
        vectors += 2;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL stream_idle: got busy %b expected 0", busy);
        end
        if (wordcnt !== 16'd16) begin
            miscompares++; $display("FAIL stream_wordcnt: got %0d expected 16", wordcnt);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] first;
        int r0, d0;
        dready = 1'b0;
        first = W'($urandom);
        push(first);
        for (int i = 0; i < 4; i++) push(W'($urandom));
        r0 = reads;
        repeat (8) cycle();
        vectors += 3;
        if (reads - r0 != 2) begin
            miscompares++; $display("FAIL bp_reads: got %0d expected 2", reads - r0);
        end
        if (dvalid !== 1'b1) begin
            miscompares++; $display("FAIL bp_dvalid: got %b expected 1", dvalid);
        end
        if (dout !== first) begin
            miscompares++; $display("FAIL bp_head: got %h expected %h", dout, first);
        end
        dready = 1'b1;
        d0 = delivered;
        for (int i = 0; i < 20 && delivered - d0 < 5; i++) cycle();
        vectors++;
        if (delivered - d0 != 5) begin
            miscompares++; $display("FAIL bp_drain: got %0d expected 5", delivered - d0);
        end
    endtask

    task automatic test_empty();
        int r0, nv;
        dready = 1'b1;
        r0 = reads;
        repeat (5) cycle();
        vectors += 2;
        if (reads != r0) begin
            miscompares++; $display("FAIL empty_reads: got %0d expected 0", reads - r0);
        end
        if (dvalid !== 1'b0) begin
            miscompares++; $display("FAIL empty_dvalid: got %b expected 0", dvalid);
        end
        push(W'($urandom));
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (dvalid === 1'b1) nv++;
        end
        vectors++;
        if (nv != 1) begin
            miscompares++; $display("FAIL single_word: got %0d valid cycles expected 1", nv);
        end
    endtask

    task automatic test_en_toggle();
        int r0, r1, d1, pending;
        en = 1'b1;
        dready = 1'b1;
        for (int i = 0; i < 4; i++) push(W'($urandom));
        r0 = reads;
        for (int i = 0; i < 10 && reads == r0; i++) cycle();
        en = 1'b0;
        r1 = reads;
        d1 = delivered;
        pending = ready_q.size() + transit_q.size();
        repeat (6) cycle();
        vectors += 2;
        if (reads != r1) begin
            miscompares++; $display("FAIL en_off_reads: got %0d expected 0", reads - r1);
        end
        if (delivered - d1 != pending || pending == 0) begin
            miscompares++;
            $display("FAIL en_off_deliver: got %0d expected %0d", delivered - d1, pending);
        end
        en = 1'b1;
        for (int i = 0; i < 30 && (fifo_q.size() != 0 || busy !== 1'b0); i++) cycle();
    endtask

    task automatic test_reset_midstream();
        int rem;
        en = 1'b1;
        dready = 1'b1;
        for (int i = 0; i < 8; i++) push(W'($urandom));
        repeat (4) cycle();
        apply_reset();
        rem = fifo_q.size();
        for (int i = 0; i < 40 && delivered < rem; i++) cycle();
        repeat (2) cycle();
        vectors++;
        if (delivered != rem) begin
            miscompares++; $display("FAIL restart: got %0d words expected %0d", delivered, rem);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            en     = ($urandom_range(0, 3) != 0);
            dready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1 && fifo_q.size() < 8) push(W'($urandom));
            cycle();
        end
        en = 1'b1;
        dready = 1'b1;
        for (int i = 0; i < 40 && (fifo_q.size() != 0 || ready_q.size() != 0 ||
                                   transit_q.size() != 0); i++) cycle();
        vectors++;
        if (ready_q.size() + transit_q.size() + fifo_q.size() != 0) begin
            miscompares++; $display("FAIL random_drain: got %0d left expected 0",
                                    ready_q.size() + transit_q.size() + fifo_q.size());
        end
    endtask

    task automatic test_wrap();
        int pushed;
        apply_reset();
        pushed = 0;
        en = 1'b1;
        dready = 1'b1;
        for (int i = 0; i < 70000 && delivered < 65537; i++) begin
            if (pushed < 65537 && fifo_q.size() < 3) begin
                push(W'(pushed));
                pushed++;
            end
            cycle();
        end
        repeat (3) cycle();
        vectors += 2;
        if (delivered != 65537) begin
            miscompares++; $display("FAIL wrap_count: got %0d expected 65537", delivered);
        end
        if (wordcnt !== 16'd1) begin
            miscompares++; $display("FAIL wrap_wordcnt: got %0d expected 1", wordcnt);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty();
        test_en_toggle();
        test_reset_midstream();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
